// File: rtl/balance_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : balance_arbiter_pkg
// Purpose : Shared types and constants for the shared-balance arbiter.
// Revision: 1.0 - initial release
// ============================================================================
package balance_arbiter_pkg;

    // Transaction FSM: idle, apply operation, respond with ACK.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // TIPO encoding.
    localparam logic TIPO_DEPOSITO = 1'b0;
    localparam logic TIPO_RETIRO   = 1'b1;

    // Default datapath widths.
    localparam int DEF_BAL_W   = 64;
    localparam int DEF_MONTO_W = 32;

endpackage : balance_arbiter_pkg
`default_nettype wire

// File: rtl/balance_arbiter_rr_arbiter_2.sv
`default_nettype none
// ============================================================================
// Module  : rr_arbiter_2
// Purpose : Two-way round-robin arbiter. Produces a one-hot grant while
//           enabled and remembers the last granted index so that a tie is
//           always resolved in favour of the other requester.
// Revision: 1.0 - initial release
// ============================================================================
module rr_arbiter_2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    input  logic       en_i,
    output logic [1:0] gnt_o
);

    // Index of the last granted requester; reset to 1 so ATM0 wins the first tie.
    logic last_q;

    // Grant selection: tie goes to the requester not served last.
    always_comb begin
        gnt_o = 2'b00;
        if (en_i) begin
            if (req_i == 2'b11) begin
                gnt_o = last_q ? 2'b01 : 2'b10;
            end else begin
                gnt_o = req_i;
            end
        end
    end

    // Pointer moves only when a grant is actually issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else if (|gnt_o) begin
            last_q <= gnt_o[1];
        end
    end

endmodule : rr_arbiter_2
`default_nettype wire

// File: rtl/balance_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : balance_arbiter
// Purpose : Owns the shared account balance and serializes deposit/withdraw
//           requests from two ATM controllers with round-robin fairness.
//           Each transaction takes IDLE -> EXEC -> RESP (one per 3 cycles).
// Revision: 1.0 - initial release
// ============================================================================
module balance_arbiter
    import balance_arbiter_pkg::*;
#(
    parameter int               BAL_W           = DEF_BAL_W,
    parameter int               MONTO_W         = DEF_MONTO_W,
    parameter logic [BAL_W-1:0] BALANCE_INICIAL = BAL_W'(500)
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               REQ0,
    input  logic               REQ1,
    input  logic               TIPO0,
    input  logic               TIPO1,
    input  logic [MONTO_W-1:0] MONTO0,
    input  logic [MONTO_W-1:0] MONTO1,
    output logic               GNT0,
    output logic               GNT1,
    output logic               ACK0,
    output logic               ACK1,
    output logic               DONE,
    output logic               INSUF,
    output logic               BUSY,
    output logic [BAL_W-1:0]   BALANCE
);

    localparam logic [BAL_W-1:0] BAL_MAX = {BAL_W{1'b1}};

    state_t             state_q, state_d;
    logic [1:0]         gnt_q, gnt_d;
    logic               tipo_q, tipo_d;
    logic [MONTO_W-1:0] monto_q, monto_d;
    logic [BAL_W-1:0]   bal_q, bal_d;
    logic               ok_q, ok_d;       // 1 = applied, 0 = insufficient funds

    logic [1:0]         arb_gnt;
    logic [BAL_W-1:0]   monto_ext;
    logic [BAL_W:0]     sum_wide;
    logic [BAL_W-1:0]   dep_result;
    logic               short_funds;

    // Arbitration only happens while idle, so LAST moves once per transaction.
    rr_arbiter_2 u_rr (
        .clk   (Clk),
        .rst_n (Reset),
        .req_i ({REQ1, REQ0}),
        .en_i  (state_q == ST_IDLE),
        .gnt_o (arb_gnt)
    );

    // Balance datapath on the latched operands: saturating add, funds check.
    always_comb begin
        monto_ext   = BAL_W'(monto_q);
        sum_wide    = {1'b0, bal_q} + {1'b0, monto_ext};
        dep_result  = sum_wide[BAL_W] ? BAL_MAX : sum_wide[BAL_W-1:0];
        short_funds = (monto_ext > bal_q);
    end

    // Next-state and operand/balance update logic.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        tipo_d  = tipo_q;
        monto_d = monto_q;
        bal_d   = bal_q;
        ok_d    = ok_q;
        unique case (state_q)
            ST_IDLE: begin
                if (|arb_gnt) begin
                    gnt_d   = arb_gnt;
                    tipo_d  = arb_gnt[1] ? TIPO1  : TIPO0;
                    monto_d = arb_gnt[1] ? MONTO1 : MONTO0;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (tipo_q == TIPO_DEPOSITO) begin
                    bal_d = dep_result;
                    ok_d  = 1'b1;
                end else if (short_funds) begin
                    ok_d  = 1'b0;
                end else begin
                    bal_d = bal_q - monto_ext;
                    ok_d  = 1'b1;
                end
                state_d = ST_RESP;
            end
            ST_RESP: begin
                gnt_d   = 2'b00;
                state_d = ST_IDLE;
            end
            default: begin
                gnt_d   = 2'b00;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, operand latch and balance register; reset discards any transaction.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= ST_IDLE;
            gnt_q   <= 2'b00;
            tipo_q  <= TIPO_DEPOSITO;
            monto_q <= '0;
            bal_q   <= BALANCE_INICIAL;
            ok_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            tipo_q  <= tipo_d;
            monto_q <= monto_d;
            bal_q   <= bal_d;
            ok_q    <= ok_d;
        end
    end

    // Outputs decoded from registered state only; results gated to RESP.
    always_comb begin
        GNT0    = gnt_q[0];
        GNT1    = gnt_q[1];
        ACK0    = gnt_q[0] && (state_q == ST_RESP);
        ACK1    = gnt_q[1] && (state_q == ST_RESP);
        DONE    = (state_q == ST_RESP) && ok_q;
        INSUF   = (state_q == ST_RESP) && !ok_q;
        BUSY    = (state_q != ST_IDLE);
        BALANCE = bal_q;
    end

endmodule : balance_arbiter
`default_nettype wire

// File: tb/tb_balance_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_balance_arbiter
// Purpose : Self-checking bench for balance_arbiter: directed scenarios with
//           literal expectations plus randomized traffic against a
//           transaction-level reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_balance_arbiter;

    localparam longint unsigned MAX64   = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [32:0]     SAT_INI = 33'h1_FFFF_FFF6;   // 2^33 - 10
    localparam logic [32:0]     SAT_MAX = 33'h1_FFFF_FFFF;   // 2^33 - 1

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic [1:0]  req = 2'b00;
    logic [1:0]  tipo = 2'b00;
    logic [31:0] monto0 = '0, monto1 = '0;
    logic        GNT0, GNT1, ACK0, ACK1, DONE, INSUF, BUSY;
    logic [63:0] BALANCE;

    // Saturation instance (33-bit balance)
    logic        sreq = 1'b0;
    logic [31:0] smonto = '0;
    logic        SGNT0, SGNT1, SACK0, SACK1, SDONE, SINSUF, SBUSY;
    logic [32:0] SBALANCE;

    int tests = 0;
    int fails = 0;

    always #5 Clk = ~Clk;

    balance_arbiter dut (
        .Clk(Clk), .Reset(Reset),
        .REQ0(req[0]), .REQ1(req[1]), .TIPO0(tipo[0]), .TIPO1(tipo[1]),
        .MONTO0(monto0), .MONTO1(monto1),
        .GNT0(GNT0), .GNT1(GNT1), .ACK0(ACK0), .ACK1(ACK1),
        .DONE(DONE), .INSUF(INSUF), .BUSY(BUSY), .BALANCE(BALANCE)
    );

    balance_arbiter #(.BAL_W(33), .MONTO_W(32), .BALANCE_INICIAL(SAT_INI)) dut_sat (
        .Clk(Clk), .Reset(Reset),
        .REQ0(sreq), .REQ1(1'b0), .TIPO0(1'b0), .TIPO1(1'b0),
        .MONTO0(smonto), .MONTO1(32'd0),
        .GNT0(SGNT0), .GNT1(SGNT1), .ACK0(SACK0), .ACK1(SACK1),
        .DONE(SDONE), .INSUF(SINSUF), .BUSY(SBUSY), .BALANCE(SBALANCE)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     nm, act, act, exp, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: a transaction is either absent or has an age in
    // cycles since its grant; the outcome is decided from the rules with
    // plain arithmetic and committed to the balance one cycle after grant.
    // ------------------------------------------------------------------
    int              m_age   = 0;      // 0: none, 1: granted, 2: responding
    int              m_win   = 0;
    bit              m_last  = 1'b1;
    bit              m_tipo  = 1'b0;
    longint unsigned m_monto = 0;
    longint unsigned m_bal   = 500;
    bit              m_ok    = 1'b0;

    always @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            m_age  = 0;
            m_bal  = 500;
            m_last = 1'b1;
        end else begin
            if (m_age == 0) begin
                if (req != 2'b00) begin
                    if (req == 2'b11) m_win = m_last ? 0 : 1;
                    else              m_win = req[1] ? 1 : 0;
                    m_last  = (m_win == 1);
                    m_tipo  = tipo[m_win];
                    m_monto = (m_win == 1) ? longint'(monto1) : longint'(monto0);
                    m_age   = 1;
                end
            end else if (m_age == 1) begin
                if (!m_tipo) begin
                    m_ok  = 1'b1;
                    m_bal = (m_monto > MAX64 - m_bal) ? MAX64 : m_bal + m_monto;
                end else if (m_monto <= m_bal) begin
                    m_ok  = 1'b1;
                    m_bal = m_bal - m_monto;
                end else begin
                    m_ok  = 1'b0;
                end
                m_age = 2;
            end else begin
                m_age = 0;
            end
        end
    end

    // Cycle-by-cycle comparison of every output against the model.
    always @(negedge Clk) begin
        logic [1:0] e_gnt, e_ack;
        e_gnt = (m_age != 0) ? (2'b01 << m_win) : 2'b00;
        e_ack = (m_age == 2) ? (2'b01 << m_win) : 2'b00;
        chk("gnt",     {62'd0, GNT1, GNT0}, {62'd0, e_gnt});
        chk("ack",     {62'd0, ACK1, ACK0}, {62'd0, e_ack});
        chk("done",    {63'd0, DONE},  {63'd0, (m_age == 2) &&  m_ok});
        chk("insuf",   {63'd0, INSUF}, {63'd0, (m_age == 2) && !m_ok});
        chk("busy",    {63'd0, BUSY},  {63'd0, m_age != 0});
        chk("balance", BALANCE, m_bal);
    end

    // One directed transaction on the main instance; call at a falling edge
    // with the DUT idle. Checks latency and literal result.
    task automatic txn(input int idx, input bit t, input logic [31:0] m,
                       input bit exp_done, input longint unsigned exp_bal);
        int n;
        bit got;
        tipo[idx] = t;
        if (idx == 0) monto0 = m; else monto1 = m;
        req[idx] = 1'b1;
        n = 0;
        got = 1'b0;
        while (!got && n < 10) begin
            @(negedge Clk);
            n++;
            got = (idx == 0) ? ACK0 : ACK1;
        end
        chk("txn_ack_latency", 64'(n), 64'd2);
        chk("txn_done",  {63'd0, DONE},  {63'd0, exp_done});
        chk("txn_insuf", {63'd0, INSUF}, {63'd0, !exp_done});
        chk("txn_balance", BALANCE, exp_bal);
        req[idx] = 1'b0;
        @(negedge Clk);
    endtask

    initial begin
        int n, acks;
        int order [4];

        // Reset state
        repeat (2) @(negedge Clk);
        chk("rst_busy",    {63'd0, BUSY}, 64'd0);
        chk("rst_gnt",     {62'd0, GNT1, GNT0}, 64'd0);
        chk("rst_balance", BALANCE, 64'd500);
        chk("rst_sat_balance", {31'd0, SBALANCE}, {31'd0, SAT_INI});
        Reset = 1'b1;

        // Saturating deposit on the 33-bit build
        @(negedge Clk);
        smonto = 32'd100;
        sreq   = 1'b1;
        n = 0;
        while (!SACK0 && n < 10) begin
            @(negedge Clk);
            n++;
        end
        chk("sat_ack_latency", 64'(n), 64'd2);
        chk("sat_done",    {63'd0, SDONE}, 64'd1);
        chk("sat_balance", {31'd0, SBALANCE}, {31'd0, SAT_MAX});
        sreq = 1'b0;
        @(negedge Clk);

        // Basic deposit / withdraw / insufficient funds
        txn(0, 1'b0, 32'd10000, 1'b1, 64'd10500);
        txn(0, 1'b1, 32'd9000,  1'b1, 64'd1500);
        txn(0, 1'b1, 32'd2000,  1'b0, 64'd1500);

        // Reset so LAST=1 again, then a sustained tie
        Reset = 1'b0;
        @(negedge Clk);
        Reset = 1'b1;
        tipo   = 2'b00;
        monto0 = 32'd100;
        monto1 = 32'd100;
        req    = 2'b11;
        acks = 0;
        n = 0;
        while (acks < 4 && n < 30) begin
            @(negedge Clk);
            n++;
            if (ACK0 || ACK1) begin
                order[acks] = ACK1 ? 1 : 0;
                acks++;
                if (acks == 4) req = 2'b00;
            end
        end
        chk("tie_ack_count", 64'(acks), 64'd4);
        for (int k = 0; k < 4; k++) chk("tie_order", 64'(order[k]), 64'(k % 2));
        chk("tie_balance", BALANCE, 64'd900);
        @(negedge Clk);

        // Exact-balance withdraw and zero deposit
        txn(1, 1'b0, 32'd600,  1'b1, 64'd1500);
        txn(0, 1'b1, 32'd1500, 1'b1, 64'd0);
        txn(1, 1'b0, 32'd0,    1'b1, 64'd0);
        txn(0, 1'b0, 32'd50,   1'b1, 64'd50);

        // Asynchronous reset while a withdraw is in EXEC
        tipo[0] = 1'b1;
        monto0  = 32'd20;
        req[0]  = 1'b1;
        @(posedge Clk);
        #1;
        chk("exec_gnt_before_rst", {63'd0, GNT0}, 64'd1);
        #1;
        Reset = 1'b0;
        #1;
        chk("async_rst_gnt",     {63'd0, GNT0}, 64'd0);
        chk("async_rst_busy",    {63'd0, BUSY}, 64'd0);
        chk("async_rst_balance", BALANCE, 64'd500);
        req[0] = 1'b0;
        repeat (2) @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);

        // Randomized traffic against the model
        repeat (600) begin
            @(negedge Clk);
            for (int i = 0; i < 2; i++) begin
                bit ack_i, gnt_i;
                ack_i = (i == 0) ? ACK0 : ACK1;
                gnt_i = (i == 0) ? GNT0 : GNT1;
                if (req[i] && ack_i) begin
                    req[i] = 1'b0;
                end else if (req[i] && gnt_i && ($urandom_range(0, 15) == 0)) begin
                    req[i] = 1'b0;
                end else if (!req[i] && ($urandom_range(0, 2) == 0)) begin
                    logic [31:0] m;
                    m = ($urandom_range(0, 7) == 0) ? 32'($urandom) : 32'($urandom_range(0, 2000));
                    tipo[i] = 1'($urandom_range(0, 1));
                    if (i == 0) monto0 = m; else monto1 = m;
                    req[i] = 1'b1;
                end
            end
        end
        req = 2'b00;
        repeat (4) @(negedge Clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_balance_arbiter
`default_nettype wire

// File: doc/balance_arbiter.md
# balance_arbiter

Shared-balance arbiter for two ATM transaction controllers. Owns the single account balance register and serializes deposit/withdraw requests from two requesters (ATM0, ATM1) with round-robin fairness. Each granted request is checked for sufficient funds, applied atomically and acknowledged with a one-cycle result pulse. Sits between the per-ATM controllers (which drive their own BALANCE_ACTUALIZADO / ENTREGAR_DINERO / FONDOS_INSUFICIENTES from this block's results) and the balance storage.

## Interface
- BAL_W, 64, balance register width
- MONTO_W, 32, transaction amount width
- BALANCE_INICIAL, 500, balance loaded on reset
- Clk  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-low reset
- REQ0, REQ1  in  1 each  transaction request, level, held until matching ACK
- TIPO0, TIPO1  in  1 each  0 = deposit, 1 = withdraw; stable while REQ high
- MONTO0, MONTO1  in  MONTO_W each  amount; stable while REQ high
- GNT0, GNT1  out  1 each  one-hot grant, high from grant through ACK cycle
- ACK0, ACK1  out  1 each  one-cycle completion pulse
- DONE  out  1  valid with ACK: transaction applied
- INSUF  out  1  valid with ACK: withdraw rejected, funds insufficient
- BUSY  out  1  high whenever state != IDLE
- BALANCE  out  BAL_W  current balance

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE: if any REQ high, pick winner, latch its TIPO/MONTO, assert its GNT, go EXEC; else stay.
- Arbitration: round-robin, pointer LAST = last granted index. Both REQ high → grant !LAST. Single REQ → grant it. LAST updates only on grant.
- EXEC: deposit → BALANCE += MONTO, saturating at 2^BAL_W−1, DONE=1. Withdraw with MONTO ≤ BALANCE → BALANCE −= MONTO, DONE=1. Withdraw with MONTO > BALANCE → BALANCE unchanged, INSUF=1. Equal amount allowed (balance → 0). MONTO = 0 is a valid no-op with DONE=1. Go RESP.
- RESP: ACK of granted requester high, DONE/INSUF valid, GNT held; go IDLE. Non-granted REQ is ignored and stays pending.
- DONE and INSUF are mutually exclusive and zero outside RESP.
- Requester must drop REQ the cycle after it sees ACK; REQ still high in IDLE is a new request.

## Timing
- Reset (Reset=0, asynchronous): state IDLE, BALANCE = BALANCE_INICIAL, LAST = 1 (ATM0 wins first tie), all GNT/ACK/DONE/INSUF/BUSY = 0. In-flight transaction discarded, no ACK issued.
- REQ sampled in IDLE at edge N → GNT/BUSY high after N; BALANCE updated and ACK/DONE/INSUF high after edge N+1; all cleared after edge N+2 (back to IDLE).
- Latency 2 cycles request-sample to ACK; throughput one transaction per 3 cycles.
- Both REQ continuously high → grants alternate; a waiting requester is served within one transaction.
- REQ dropped by requester after grant: transaction still completes on latched operands.
- Reset released: first REQ can be sampled on the first rising edge with Reset=1.

## Structure
- Shared package: state enum (IDLE/EXEC/RESP), TIPO_DEPOSITO=0 / TIPO_RETIRO=1 constants, default BAL_W/MONTO_W.
- Sub-module rr_arbiter_2: two requests + enable → one-hot grant and LAST pointer register; the top holds FSM, operand latch and balance datapath.

## Test plan
- Reset, ATM0 deposit 10000 → ACK0 after 2 cycles, DONE=1, BALANCE=10500.
- ATM0 withdraw 9000 → DONE=1, BALANCE=1500; then withdraw 2000 → INSUF=1, DONE=0, BALANCE stays 1500.
- REQ0 and REQ1 same cycle (deposit 100 each), held continuously for 4 transactions → grant order ATM0, ATM1, ATM0, ATM1; BALANCE +400.
- Withdraw exactly 1500 from 1500 → DONE=1, BALANCE=0; deposit 0 → DONE=1, BALANCE=0.
- Reset asserted in EXEC with a withdraw pending → no ACK, BALANCE=500, GNT/BUSY=0 immediately (asynchronous).
- BALANCE forced near max (BAL_W=33 build, BALANCE_INICIAL=2^33−10), deposit 100 → BALANCE=2^33−1, DONE=1.
